text_console_writer: RTL and testbench

TEXT_CONSOLE_WRITER -- requirements
Module: text_console_writer

---
 rtl/text_console_writer.sv | 158 +++++++++++++++
 tb/tb_text_console_writer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/text_console_writer.sv
// Character-stream to text-RAM writer: places printable codes at the cursor,
// handles CR/LF/BS, and blanks the whole RAM or the new line when required.
module text_console_writer #(
  parameter int         COLS  = 60,
  parameter int         ROWS  = 34,
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic        PIXEL_CLK,
  input  logic        RESETn,
  input  logic        CHAR_VALID,
  input  logic [7:0]  CHAR_DATA,
  output logic        CHAR_READY,
  input  logic        CLEAR,
  output logic [11:0] RAM_AD,
  output logic [7:0]  RAM_DIN,
  output logic        RAM_WRE,
  output logic [5:0]  CURSOR_X,
  output logic [5:0]  CURSOR_Y,
  output logic        BUSY
);

  localparam logic [1:0] CLR_ALL  = 2'd0;
  localparam logic [1:0] IDLE     = 2'd1;
  localparam logic [1:0] WRITE    = 2'd2;
  localparam logic [1:0] CLR_LINE = 2'd3;

  localparam logic [5:0] LAST_COL = 6'(COLS - 1);
  localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);

  logic [1:0]  state_reg;
  logic [11:0] ad_reg;
  logic [7:0]  din_reg;
  logic        wre_reg;
  logic [5:0]  x_reg;
  logic [5:0]  y_reg;
  logic        adv_reg;

  // Bit 7 of the character code carries no meaning for this console.
  logic [6:0] code;
  logic       unused_msb;
  assign code       = CHAR_DATA[6:0];
  assign unused_msb = CHAR_DATA[7];

  logic is_print;
  logic is_lf;
  logic is_cr;
  logic is_bs;
  logic [5:0] row_after;
  logic       at_last_col;

  assign is_print    = (code >= 7'h20) && (code != 7'h7F);
  assign is_lf       = (code == 7'h0A);
  assign is_cr       = (code == 7'h0D);
  assign is_bs       = (code == 7'h08);
  assign row_after   = (y_reg == LAST_ROW) ? 6'd0 : y_reg + 6'd1;
  assign at_last_col = (x_reg == LAST_COL);

  // After reset the FSM sits in CLR_ALL with the write enable low; that
  // "pending" condition makes the first edge present address 0.
  always_ff @(posedge PIXEL_CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_reg <= CLR_ALL;
      ad_reg    <= 12'd0;
      din_reg   <= BLANK;
      wre_reg   <= 1'b0;
      x_reg     <= 6'd0;
      y_reg     <= 6'd0;
      adv_reg   <= 1'b0;
    end else begin
      case (state_reg)
        CLR_ALL: begin
          if (!wre_reg) begin
            wre_reg <= 1'b1;
            ad_reg  <= 12'd0;
            din_reg <= BLANK;
          end else if (ad_reg == 12'hFFF) begin
            state_reg <= IDLE;
            wre_reg   <= 1'b0;
          end else begin
            ad_reg <= ad_reg + 12'd1;
          end
        end

        IDLE: begin
          if (CLEAR) begin
            state_reg <= CLR_ALL;
            wre_reg   <= 1'b1;
            ad_reg    <= 12'd0;
            din_reg   <= BLANK;
            x_reg     <= 6'd0;
            y_reg     <= 6'd0;
          end else if (CHAR_VALID) begin
            if (is_print) begin
              state_reg <= WRITE;
              wre_reg   <= 1'b1;
              ad_reg    <= {y_reg, x_reg};
              din_reg   <= {1'b0, code};
              adv_reg   <= 1'b1;
            end else if (is_lf) begin
              state_reg <= CLR_LINE;
              wre_reg   <= 1'b1;
              ad_reg    <= {row_after, 6'd0};
              din_reg   <= BLANK;
              x_reg     <= 6'd0;
              y_reg     <= row_after;
            end else if (is_cr) begin
              x_reg <= 6'd0;
            end else if (is_bs && (x_reg != 6'd0)) begin
              state_reg <= WRITE;
              wre_reg   <= 1'b1;
              ad_reg    <= {y_reg, x_reg - 6'd1};
              din_reg   <= BLANK;
              x_reg     <= x_reg - 6'd1;
              adv_reg   <= 1'b0;
            end
          end
        end

        WRITE: begin
          // A printable written in the last column wraps straight into a line clear.
          if (adv_reg && at_last_col) begin
            state_reg <= CLR_LINE;
            wre_reg   <= 1'b1;
            ad_reg    <= {row_after, 6'd0};
            din_reg   <= BLANK;
            x_reg     <= 6'd0;
            y_reg     <= row_after;
          end else begin
            state_reg <= IDLE;
            wre_reg   <= 1'b0;
            if (adv_reg) begin
              x_reg <= x_reg + 6'd1;
            end
          end
          adv_reg <= 1'b0;
        end

        default: begin
          if (ad_reg[5:0] == 6'd63) begin
            state_reg <= IDLE;
            wre_reg   <= 1'b0;
          end else begin
            ad_reg <= {ad_reg[11:6], ad_reg[5:0] + 6'd1};
          end
        end
      endcase
    end
  end

  assign CHAR_READY = (state_reg == IDLE);
  assign BUSY       = (state_reg != IDLE);
  assign RAM_AD     = ad_reg;
  assign RAM_DIN    = din_reg;
  assign RAM_WRE    = wre_reg;
  assign CURSOR_X   = x_reg;
  assign CURSOR_Y   = y_reg;

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer: keeps a shadow copy of the text RAM
// built from observed writes and compares it with hand-derived contents.
module tb_text_console_writer;

  logic        PIXEL_CLK = 1'b0;
  logic        RESETn;
  logic        CHAR_VALID;
  logic [7:0]  CHAR_DATA;
  logic        CHAR_READY;
  logic        CLEAR;
  logic [11:0] RAM_AD;
  logic [7:0]  RAM_DIN;
  logic        RAM_WRE;
  logic [5:0]  CURSOR_X;
  logic [5:0]  CURSOR_Y;
  logic        BUSY;

  text_console_writer #(.COLS(60), .ROWS(34), .BLANK(8'h20)) dut (
    .PIXEL_CLK (PIXEL_CLK),
    .RESETn    (RESETn),
    .CHAR_VALID(CHAR_VALID),
    .CHAR_DATA (CHAR_DATA),
    .CHAR_READY(CHAR_READY),
    .CLEAR     (CLEAR),
    .RAM_AD    (RAM_AD),
    .RAM_DIN   (RAM_DIN),
    .RAM_WRE   (RAM_WRE),
    .CURSOR_X  (CURSOR_X),
    .CURSOR_Y  (CURSOR_Y),
    .BUSY      (BUSY)
  );

  always #5 PIXEL_CLK = ~PIXEL_CLK;

  logic [7:0]  mem [0:4095];
  int          wr_count;
  int          seq_err;
  int          z_count;
  logic        track_seq;
  logic [11:0] exp_addr;
  int          passed;
  int          total;

  // Shadow RAM plus an ascending-blank-sequence tracker for full clears.
  always @(posedge PIXEL_CLK) begin
    if (RAM_WRE === 1'b1) begin
      mem[RAM_AD] = RAM_DIN;
      wr_count++;
      if (RAM_DIN == 8'h5A) z_count++;
      if (track_seq) begin
        if (RAM_AD !== exp_addr || RAM_DIN !== 8'h20) seq_err++;
        exp_addr = exp_addr + 12'd1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (CHAR_READY !== 1'b1 && n < budget) begin
      @(negedge PIXEL_CLK);
      n++;
    end
    if (CHAR_READY !== 1'b1) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic send(input logic [7:0] c);
    wait_ready(5000);
    CHAR_DATA  = c;
    CHAR_VALID = 1'b1;
    @(posedge PIXEL_CLK);
    #1;
    CHAR_VALID = 1'b0;
    @(negedge PIXEL_CLK);
  endtask

  task automatic poison(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) mem[i] = 8'hEE;
  endtask

  function automatic int count_bad(input int lo, input int hi, input logic [7:0] val);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (mem[i] !== val) n++;
    return n;
  endfunction

  task automatic start_seq();
    exp_addr  = 12'd0;
    seq_err   = 0;
    wr_count  = 0;
    track_seq = 1'b1;
  endtask

  initial begin
    int bad;
    passed = 0; total = 0;
    wr_count = 0; seq_err = 0; z_count = 0;
    track_seq = 1'b0; exp_addr = 12'd0;
    RESETn = 1'b0; CHAR_VALID = 1'b0; CHAR_DATA = 8'h00; CLEAR = 1'b0;
    poison(0, 4095);

    // Reset values
    #22;
    check("rst_ready", CHAR_READY, 1'b0);
    check("rst_busy", BUSY, 1'b1);
    check("rst_wre", RAM_WRE, 1'b0);
    check("rst_ad", RAM_AD, 12'h000);
    check("rst_din", RAM_DIN, 8'h20);
    check("rst_cursor", {CURSOR_Y, CURSOR_X}, 12'h000);

    // V-1: power-up clear
    @(negedge PIXEL_CLK);
    RESETn = 1'b1;
    start_seq();
    @(posedge PIXEL_CLK); #1;
    check("v1_first_wre", RAM_WRE, 1'b1);
    check("v1_first_ad", RAM_AD, 12'h000);
    wait_ready(5000);
    track_seq = 1'b0;
    check("v1_wr_count", wr_count, 4096);
    check("v1_seq_err", seq_err, 0);
    check("v1_all_blank", count_bad(0, 4095, 8'h20), 0);
    check("v1_cursor", {CURSOR_Y, CURSOR_X}, 12'h000);

    // V-2: back-to-back 'A','B'
    send(8'h41);
    check("v2_a_ready", CHAR_READY, 1'b0);
    check("v2_a_wre", RAM_WRE, 1'b1);
    check("v2_a_ad", RAM_AD, 12'h000);
    check("v2_a_din", RAM_DIN, 8'h41);
    @(negedge PIXEL_CLK);
    check("v2_a_ready_back", CHAR_READY, 1'b1);
    send(8'h42);
    check("v2_b_ad", RAM_AD, 12'h001);
    check("v2_b_din", RAM_DIN, 8'h42);
    wait_ready(10);
    check("v2_mem0", mem[0], 8'h41);
    check("v2_mem1", mem[1], 8'h42);
    check("v2_cursor", {CURSOR_Y, CURSOR_X}, {6'd0, 6'd2});

    // V-3: full line of 60 wraps to row 1 and blanks it
    send(8'h0D);
    poison(12'h040, 12'h07F);
    wr_count = 0;
    for (int i = 0; i < 60; i++) send(8'h41 + 8'(i % 26));
    wait_ready(200);
    bad = 0;
    for (int i = 0; i < 60; i++) if (mem[i] !== 8'h41 + 8'(i % 26)) bad++;
    check("v3_row0_text", bad, 0);
    check("v3_last_char", mem[12'h03B], 8'h48);
    check("v3_row1_blank", count_bad(12'h040, 12'h07F, 8'h20), 0);
    check("v3_wr_count", wr_count, 124);
    check("v3_cursor", {CURSOR_Y, CURSOR_X}, {6'd1, 6'd0});

    // V-4: LF on last row wraps to row 0; CR returns to column 0
    for (int i = 0; i < 32; i++) send(8'h0A);
    for (int i = 0; i < 5; i++) send(8'h71);
    wait_ready(10);
    check("v4_pre_cursor", {CURSOR_Y, CURSOR_X}, {6'd33, 6'd5});
    poison(0, 12'h03F);
    wr_count = 0;
    send(8'h0A);
    wait_ready(200);
    check("v4_wrap_cursor", {CURSOR_Y, CURSOR_X}, 12'h000);
    check("v4_row0_blank", count_bad(0, 12'h03F, 8'h20), 0);
    check("v4_wr_count", wr_count, 64);
    send(8'h0A); send(8'h0A);
    for (int i = 0; i < 7; i++) send(8'h71);
    wait_ready(10);
    check("v4_cr_pre", {CURSOR_Y, CURSOR_X}, {6'd2, 6'd7});
    wr_count = 0;
    send(8'h0D);
    check("v4_cr_ready", CHAR_READY, 1'b1);
    check("v4_cr_cursor", {CURSOR_Y, CURSOR_X}, {6'd2, 6'd0});
    @(negedge PIXEL_CLK);
    check("v4_cr_nowrite", wr_count, 0);

    // CLEAR while a line clear is running is ignored
    wr_count = 0;
    send(8'h0A);
    CLEAR = 1'b1;
    @(negedge PIXEL_CLK);
    CLEAR = 1'b0;
    wait_ready(200);
    check("clr_busy_ignored", wr_count, 64);
    check("clr_busy_cursor", {CURSOR_Y, CURSOR_X}, {6'd3, 6'd0});
    send(8'h0A);

    // V-5: backspace, bit-7 masking, BS at column 0, control codes
    send(8'h78); send(8'h79); send(8'h7A);
    wait_ready(10);
    check("v5_pre_mem", mem[12'h102], 8'h7A);
    send(8'h08);
    wait_ready(10);
    check("v5_bs_mem", mem[12'h102], 8'h20);
    check("v5_bs_cursor", {CURSOR_Y, CURSOR_X}, {6'd4, 6'd2});
    send(8'hC1);
    wait_ready(10);
    check("v5_msb_mem", mem[12'h102], 8'h41);
    check("v5_msb_cursor", {CURSOR_Y, CURSOR_X}, {6'd4, 6'd3});
    send(8'h0D);
    wr_count = 0;
    send(8'h08);
    check("v5_bs0_ready", CHAR_READY, 1'b1);
    check("v5_bs0_cursor", {CURSOR_Y, CURSOR_X}, {6'd4, 6'd0});
    send(8'h07);
    check("v5_bel_ready", CHAR_READY, 1'b1);
    send(8'h7F);
    @(negedge PIXEL_CLK);
    check("v5_ctrl_cursor", {CURSOR_Y, CURSOR_X}, {6'd4, 6'd0});
    check("v5_ctrl_nowrite", wr_count, 0);

    // V-6: CLEAR beats CHAR_VALID, then reset mid-clear restarts at 0
    wait_ready(10);
    z_count = 0;
    start_seq();
    CLEAR = 1'b1; CHAR_VALID = 1'b1; CHAR_DATA = 8'h5A;
    @(posedge PIXEL_CLK); #1;
    CLEAR = 1'b0; CHAR_VALID = 1'b0;
    check("v6_clr_ready", CHAR_READY, 1'b0);
    check("v6_clr_wre", RAM_WRE, 1'b1);
    check("v6_clr_ad", RAM_AD, 12'h000);
    check("v6_clr_din", RAM_DIN, 8'h20);
    check("v6_clr_cursor", {CURSOR_Y, CURSOR_X}, 12'h000);
    for (int i = 0; i < 1000; i++) @(negedge PIXEL_CLK);
    check("v6_no_z", z_count, 0);
    check("v6_partial_seq", seq_err, 0);
    RESETn = 1'b0;
    #1;
    check("v6_rst_wre", RAM_WRE, 1'b0);
    check("v6_rst_ad", RAM_AD, 12'h000);
    check("v6_rst_ready", CHAR_READY, 1'b0);
    @(negedge PIXEL_CLK);
    RESETn = 1'b1;
    start_seq();
    @(posedge PIXEL_CLK); #1;
    check("v6_restart_ad", RAM_AD, 12'h000);
    check("v6_restart_wre", RAM_WRE, 1'b1);
    wait_ready(5000);
    track_seq = 1'b0;
    check("v6_wr_count", wr_count, 4096);
    check("v6_seq_err", seq_err, 0);
    check("v6_all_blank", count_bad(0, 4095, 8'h20), 0);
    check("v6_cursor", {CURSOR_Y, CURSOR_X}, 12'h000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
